prog_uart_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 37 +++
 rtl/uart_rx_byte.sv | 113 +++++++++++
 rtl/prog_uart_loader.sv | 214 +++++++++++++++++++++
 tb/tb_prog_uart_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the programming-UART loader: FSM/RX state
// encodings and the "TEKN" start sequence.
package prog_loader_pkg;

    localparam logic [31:0] MAGIC    = 32'h4E4B4554;
    localparam logic [7:0]  MAGIC_B0 = MAGIC[7:0];
    localparam logic [7:0]  MAGIC_B1 = MAGIC[15:8];
    localparam logic [7:0]  MAGIC_B2 = MAGIC[23:16];
    localparam logic [7:0]  MAGIC_B3 = MAGIC[31:24];

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE
    } load_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = MAGIC_B0;
            2'd1:    b = MAGIC_B1;
            2'd2:    b = MAGIC_B2;
            default: b = MAGIC_B3;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle byte_valid_o
// on an accepted stop bit. Bad stop bits drop the byte and wait for line-high.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            meta_q, sync_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            hold_q, hold_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                // After a framing error, only a high line re-arms start detection
                if (hold_q) begin
                    if (sync_q) begin
                        hold_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (sync_q) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        hold_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= 1'b0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;

endmodule

// File: rtl/prog_uart_loader.sv
// Programming-UART loader: syncs on "TEKN", reads a word count, writes LE words to RAM
// from address 0 while holding the SoC in reset. Checksum trailer: PROG_CHECKSUM_EN.
module prog_uart_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 1085,
    parameter int RAM_DEPTH      = 131072,
    parameter int TIMEOUT_CYCLES = 12_500_000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         prog_rx_i,
    output logic                         mem_we_o,
    output logic [$clog2(RAM_DEPTH)-1:0] mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    output logic                         system_reset_o,
    output logic                         prog_mode_o,
    output logic                         error_o
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [31:0] word_shift;

    load_state_t state_q, state_d;
    logic [1:0]  midx_q, midx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] word_q, word_d;
    logic [AW:0] len_q, len_d;
    logic [AW:0] wcnt_q, wcnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic        we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        sysrst_q, sysrst_d;
    logic        prog_q, prog_d;
    logic        err_q, err_d;
`ifdef PROG_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (prog_rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid)
    );

    // Little-endian assembly: each new byte enters at the top and shifts down
    assign word_shift = {rx_byte, word_q[31:8]};

    always_comb begin
        state_d  = state_q;
        midx_d   = midx_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        idle_d   = '0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sysrst_d = sysrst_q;
        prog_d   = prog_q;
        err_d    = err_q;
`ifdef PROG_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        if (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM)
            idle_d = rx_valid ? '0 : idle_q + TW'(1);

        case (state_q)
            S_SYNC: begin
                if (rx_valid) begin
                    if (rx_byte == magic_byte(midx_q)) begin
                        if (midx_q == 2'd3) begin
                            midx_d   = '0;
                            bcnt_d   = '0;
                            state_d  = S_LEN;
                            prog_d   = 1'b1;
                            sysrst_d = 1'b0;
                        end else begin
                            midx_d = midx_q + 2'd1;
                        end
                    end else begin
                        midx_d = (rx_byte == MAGIC_B0) ? 2'd1 : 2'd0;
                    end
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    word_d = word_shift;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (word_shift == 32'd0) begin
                            state_d = S_DONE;
                        end else if (word_shift > 32'(RAM_DEPTH)) begin
                            err_d    = 1'b1;
                            state_d  = S_SYNC;
                            prog_d   = 1'b0;
                            sysrst_d = 1'b1;
                        end else begin
                            len_d   = word_shift[AW:0];
                            wcnt_d  = '0;
                            state_d = S_DATA;
`ifdef PROG_CHECKSUM_EN
                            csum_d  = '0;
`endif
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    word_d = word_shift;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wcnt_q[AW-1:0];
                        wdata_d = word_shift;
                        wcnt_d  = wcnt_q + (AW+1)'(1);
`ifdef PROG_CHECKSUM_EN
                        csum_d  = csum_q + word_shift;
                        if (wcnt_q + (AW+1)'(1) == len_q) state_d = S_CSUM;
`else
                        if (wcnt_q + (AW+1)'(1) == len_q) state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef PROG_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    word_d = word_shift;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (word_shift != csum_q) err_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
                prog_d   = 1'b0;
                sysrst_d = 1'b1;
                state_d  = S_SYNC;
            end
            default: state_d = S_SYNC;
        endcase

        // Link went silent mid-load: abandon it, keep whatever was already written
        if ((state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM) &&
            !rx_valid && idle_q == TO_M1) begin
            err_d    = 1'b1;
            state_d  = S_SYNC;
            midx_d   = '0;
            prog_d   = 1'b0;
            sysrst_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_SYNC;
            midx_q   <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            len_q    <= '0;
            wcnt_q   <= '0;
            idle_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sysrst_q <= 1'b1;
            prog_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef PROG_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            midx_q   <= midx_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            idle_q   <= idle_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sysrst_q <= sysrst_d;
            prog_q   <= prog_d;
            err_q    <= err_d;
`ifdef PROG_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign mem_we_o       = we_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign system_reset_o = sysrst_q;
    assign prog_mode_o    = prog_q;
    assign error_o        = err_q;

endmodule

// File: tb/tb_prog_uart_loader.sv
// Bench for prog_uart_loader: byte-stream model predicts writes and flags,
// a per-cycle monitor checks every RAM write and the reset/LED relationship.
`timescale 1ns/1ps
module tb_prog_uart_loader;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;
    localparam int TO    = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        mem_we_o;
    logic [3:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        system_reset_o;
    logic        prog_mode_o;
    logic        error_o;

    always #5 clk = ~clk;

    prog_uart_loader #(
        .CLKS_PER_BIT  (CPB),
        .RAM_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .prog_rx_i     (rx),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .system_reset_o(system_reset_o),
        .prog_mode_o   (prog_mode_o),
        .error_o       (error_o)
    );

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         exp_q[$];
    logic [31:0] cap[$];
    logic [7:0]  stream[$];
    logic        model_err   = 1'b0;
    int          model_loads = 0;
    logic [31:0] model_sum   = 32'd0;
    int          prog_rises  = 0;
    logic        we_prev     = 1'b0;
    logic        prog_prev   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: every write must be the next one the model predicted
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (system_reset_o !== ~prog_mode_o) begin
                bad++;
                $display("FAIL sysrst_vs_prog: system_reset_o=%b prog_mode_o=%b", system_reset_o, prog_mode_o);
            end
            if (mem_we_o === 1'b1) begin
                wr_t e;
                cap.push_back(mem_wdata_o);
                total++;
                if (we_prev) begin
                    bad++;
                    $display("FAIL back_to_back_write: addr=%h", mem_addr_o);
                end else if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: addr=%h data=%h expected none", mem_addr_o, mem_wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr_o !== e.addr || mem_wdata_o !== e.data) begin
                        bad++;
                        $display("FAIL write: got %h@%h expected %h@%h", mem_wdata_o, mem_addr_o, e.data, e.addr);
                    end
                end
            end
            if (prog_mode_o && !prog_prev) prog_rises++;
        end
        we_prev   = mem_we_o;
        prog_prev = prog_mode_o;
    end

    // Stream model: find "TEKN", read count, slice words; a short stream means timeout
    task automatic model_stream();
        int n = stream.size();
        int i = 0;
        logic [31:0] len, w, sum;
        while (i + 4 <= n) begin
            if ({stream[i+3], stream[i+2], stream[i+1], stream[i]} != 32'h4E4B4554) begin
                i++;
                continue;
            end
            i += 4;
            model_loads++;
            if (i + 4 > n) begin model_err = 1'b1; return; end
            len = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
            i += 4;
            if (len > 32'(DEPTH)) begin model_err = 1'b1; continue; end
            sum = 32'd0;
            for (int k = 0; k < int'(len); k++) begin
                if (i + 4 > n) begin model_err = 1'b1; return; end
                w = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
                i += 4;
                exp_q.push_back('{addr: 4'(k), data: w});
                sum += w;
            end
            model_sum = sum;
`ifdef PROG_CHECKSUM_EN
            if (len != 32'd0) begin
                if (i + 4 > n) begin model_err = 1'b1; return; end
                if ({stream[i+3], stream[i+2], stream[i+1], stream[i]} != sum) model_err = 1'b1;
                i += 4;
            end
`endif
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_val;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
    endtask

    task automatic send_range(input int from, input int upto);
        for (int i = from; i < upto; i++) send_frame(stream[i], 1'b1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic end_check(input string name);
        int c = 0;
        while (prog_mode_o && c < 1000) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk({name, "_load_ends"}, (c < 1000) ? 32'd1 : 32'd0, 32'd1);
        chk({name, "_error"}, {31'd0, error_o}, {31'd0, model_err});
        chk({name, "_sysrst"}, {31'd0, system_reset_o}, 32'd1);
        chk({name, "_prog"}, {31'd0, prog_mode_o}, 32'd0);
        chk({name, "_pending_writes"}, exp_q.size(), 32'd0);
        chk({name, "_loads"}, prog_rises, model_loads);
        stream.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int r0;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", {28'd0, mem_addr_o}, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_sysrst", {31'd0, system_reset_o}, 32'd1);
        chk("rst_prog", {31'd0, prog_mode_o}, 32'd0);
        chk("rst_err", {31'd0, error_o}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Two-word load
        push_word(32'h4E4B4554); push_word(32'd2);
        push_word(32'h12345678); push_word(32'hDEADBEEF);
        model_stream();
        chk("model_s1_count", exp_q.size(), 32'd2);
        chk("model_s1_word1", exp_q[1].data, 32'hDEADBEEF);
        cap.delete();
        send_range(0, 4);
        @(negedge clk);
        chk("s1_prog_after_magic", {31'd0, prog_mode_o}, 32'd1);
        chk("s1_sysrst_after_magic", {31'd0, system_reset_o}, 32'd0);
        send_range(4, stream.size());
        end_check("s1");
        chk("s1_ncap", cap.size(), 32'd2);
        if (cap.size() == 2) begin
            chk("s1_cap0", cap[0], 32'h12345678);
            chk("s1_cap1", cap[1], 32'hDEADBEEF);
        end

        // Duplicate leading 0x54, zero length
        r0 = prog_rises;
        stream.push_back(8'h54); push_word(32'h4E4B4554); push_word(32'd0);
        model_stream();
        send_range(0, stream.size());
        end_check("s2");
        chk("s2_one_pulse", prog_rises - r0, 32'd1);

        // Glitch and framing error inside the magic sequence
        cap.delete();
        push_word(32'h4E4B4554); push_word(32'd1); push_word(32'h11223344);
        model_stream();
        send_range(0, 2);
        rx = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        send_frame(stream[2], 1'b1);
        send_frame(8'h99, 1'b0);
        send_range(3, stream.size());
        end_check("s5");
        chk("s5_ncap", cap.size(), 32'd1);
        if (cap.size() == 1) chk("s5_cap0", cap[0], 32'h11223344);

        // Length larger than the RAM
        push_word(32'h4E4B4554); push_word(32'h11);
        model_stream();
        send_range(0, stream.size());
        end_check("s3");
        chk("s3_error_literal", {31'd0, error_o}, 32'd1);
        apply_reset();

        // Silence mid-word
        push_word(32'h4E4B4554); push_word(32'd1);
        stream.push_back(8'hAA); stream.push_back(8'hBB);
        model_stream();
        send_range(0, stream.size());
        end_check("s4");
        chk("s4_error_literal", {31'd0, error_o}, 32'd1);
        apply_reset();

        // Asynchronous reset during S_DATA
        push_word(32'h4E4B4554); push_word(32'd2); push_word(32'h12345678);
        stream.push_back(8'h01); stream.push_back(8'h02);
        model_stream();
        send_range(0, stream.size());
        @(negedge clk);
        chk("s6_prog_before_rst", {31'd0, prog_mode_o}, 32'd1);
        chk("s6_pending_before_rst", exp_q.size(), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("s6_we", {31'd0, mem_we_o}, 32'd0);
        chk("s6_addr", {28'd0, mem_addr_o}, 32'd0);
        chk("s6_wdata", mem_wdata_o, 32'd0);
        chk("s6_sysrst", {31'd0, system_reset_o}, 32'd1);
        chk("s6_prog", {31'd0, prog_mode_o}, 32'd0);
        chk("s6_err", {31'd0, error_o}, 32'd0);
        stream.delete();
        apply_reset();

`ifdef PROG_CHECKSUM_EN
        // Correct checksum trailer
        push_word(32'h4E4B4554); push_word(32'd3);
        push_word(32'h12345678); push_word(32'hDEADBEEF); push_word(32'h01010000);
        push_word(32'hF1E31567);
        model_stream();
        chk("model_csum", model_sum, 32'hF1E31567);
        send_range(0, stream.size());
        end_check("c1");
        chk("c1_error_literal", {31'd0, error_o}, 32'd0);

        // Wrong checksum trailer
        push_word(32'h4E4B4554); push_word(32'd3);
        push_word(32'h12345678); push_word(32'hDEADBEEF); push_word(32'h01010000);
        push_word(32'hF1E31568);
        model_stream();
        send_range(0, stream.size());
        end_check("c2");
        chk("c2_error_literal", {31'd0, error_o}, 32'd1);
        chk("c2_sysrst_literal", {31'd0, system_reset_o}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
